// File: rtl/tag_table_writer.sv
// -----------------------------------------------------------------------------
// tag_table_writer
//
// Write side of the tag-lookup table. Owns the registered tag matrix and
// per-slot valid vector that the lookup comparators read combinationally.
// Insert requests are resolved against the table state before the clock edge:
// a resident tag is reported as a hit, otherwise the lowest free slot is
// filled, otherwise the slot under the round-robin victim pointer is evicted.
// Each accepted insert produces one response (1-cycle latency) that is held
// until the consumer takes it.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   insValid/insReady/insTag
//                  insert request handshake and tag
//   invValid/invIdx
//                  single-slot invalidate (always accepted)
//   flush          clear every valid bit and the victim pointer
//   respValid/respReady
//                  insert response handshake
//   respIdx        slot that now holds (or already held) the tag
//   respHit        tag was already resident, nothing written
//   respEvict      a valid entry was overwritten
//   respEvictTag   the overwritten tag (zero when no eviction)
//   valid          registered per-slot valid vector
//   tagMat         registered tag matrix, one tag per slot
// -----------------------------------------------------------------------------
module tag_table_writer #(
    parameter int LOG_VEC_SIZE = 3,
    parameter int VEC_SIZE     = 1 << LOG_VEC_SIZE,
    parameter int TAG_SIZE     = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  insValid,
    output logic                                  insReady,
    input  logic [0:TAG_SIZE-1]                   insTag,
    input  logic                                  invValid,
    input  logic [LOG_VEC_SIZE-1:0]               invIdx,
    input  logic                                  flush,
    output logic                                  respValid,
    input  logic                                  respReady,
    output logic [LOG_VEC_SIZE-1:0]               respIdx,
    output logic                                  respHit,
    output logic                                  respEvict,
    output logic [0:TAG_SIZE-1]                   respEvictTag,
    output logic [0:VEC_SIZE-1]                   valid,
    output logic [0:VEC_SIZE-1][0:TAG_SIZE-1]     tagMat
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam logic [LOG_VEC_SIZE-1:0] IDX_ONE = 1;

    state_e                               state_q, state_d;
    logic [0:VEC_SIZE-1]                  valid_q, valid_d;
    logic [0:VEC_SIZE-1][0:TAG_SIZE-1]    tag_q, tag_d;
    logic [LOG_VEC_SIZE-1:0]              victim_q, victim_d;
    logic [LOG_VEC_SIZE-1:0]              resp_idx_q, resp_idx_d;
    logic                                 resp_hit_q, resp_hit_d;
    logic                                 resp_evict_q, resp_evict_d;
    logic [0:TAG_SIZE-1]                  resp_evict_tag_q, resp_evict_tag_d;

    logic                                 ins_fire_s;
    logic                                 hit_s;
    logic [LOG_VEC_SIZE-1:0]              hit_idx_s;
    logic                                 free_s;
    logic [LOG_VEC_SIZE-1:0]              free_idx_s;
    logic                                 wr_en_s;
    logic [LOG_VEC_SIZE-1:0]              wr_idx_s;
    logic                                 evict_s;
    logic                                 res_hit_s;
    logic [LOG_VEC_SIZE-1:0]              res_idx_s;

    assign insReady   = (state_q == ST_IDLE) || respReady;
    assign ins_fire_s = insValid && insReady;

    // Lowest matching valid slot and lowest free slot; the loop runs from the
    // top down so the final write left standing is the lowest index.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        free_s     = 1'b0;
        free_idx_s = '0;
        for (int i = VEC_SIZE - 1; i >= 0; i--) begin
            hit_s      = hit_s  | (valid_q[i] && (tag_q[i] == insTag));
            hit_idx_s  = (valid_q[i] && (tag_q[i] == insTag)) ? i[LOG_VEC_SIZE-1:0] : hit_idx_s;
            free_s     = free_s | !valid_q[i];
            free_idx_s = !valid_q[i] ? i[LOG_VEC_SIZE-1:0] : free_idx_s;
        end
    end

    // Insert resolution. A same-cycle flush makes the table look empty, so
    // the insert lands in slot 0 with no hit and no eviction.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = '0;
        evict_s   = 1'b0;
        res_hit_s = 1'b0;
        res_idx_s = '0;
        if (flush) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = '0;
            res_idx_s = '0;
        end else if (hit_s) begin
            res_hit_s = 1'b1;
            res_idx_s = hit_idx_s;
        end else if (free_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = free_idx_s;
            res_idx_s = free_idx_s;
        end else begin
            wr_en_s   = 1'b1;
            wr_idx_s  = victim_q;
            evict_s   = 1'b1;
            res_idx_s = victim_q;
        end
    end

    // Table, victim pointer, response and FSM next state.
    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        tag_d            = tag_q;
        victim_d         = victim_q;
        resp_idx_d       = resp_idx_q;
        resp_hit_d       = resp_hit_q;
        resp_evict_d     = resp_evict_q;
        resp_evict_tag_d = resp_evict_tag_q;

        // Clears first, so an insert writing the invalidated slot wins.
        if (flush) begin
            valid_d = '0;
        end else if (invValid) begin
            valid_d[invIdx] = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (ins_fire_s && wr_en_s) begin
            valid_d[wr_idx_s] = 1'b1;
            tag_d[wr_idx_s]   = insTag;
        end else begin
            tag_d = tag_q;
        end

        if (flush) begin
            victim_d = '0;
        end else if (ins_fire_s && evict_s) begin
            victim_d = victim_q + IDX_ONE;
        end else begin
            victim_d = victim_q;
        end

        if (ins_fire_s) begin
            resp_idx_d       = res_idx_s;
            resp_hit_d       = res_hit_s;
            resp_evict_d     = evict_s;
            resp_evict_tag_d = evict_s ? tag_q[victim_q] : '0;
        end else begin
            resp_idx_d = resp_idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (ins_fire_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (ins_fire_s) begin
                    state_d = ST_RESP;
                end else if (respReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            valid_q          <= '0;
            tag_q            <= '0;
            victim_q         <= '0;
            resp_idx_q       <= '0;
            resp_hit_q       <= 1'b0;
            resp_evict_q     <= 1'b0;
            resp_evict_tag_q <= '0;
        end else begin
            state_q          <= state_d;
            valid_q          <= valid_d;
            tag_q            <= tag_d;
            victim_q         <= victim_d;
            resp_idx_q       <= resp_idx_d;
            resp_hit_q       <= resp_hit_d;
            resp_evict_q     <= resp_evict_d;
            resp_evict_tag_q <= resp_evict_tag_d;
        end
    end

    assign respValid    = (state_q == ST_RESP);
    assign respIdx      = resp_idx_q;
    assign respHit      = resp_hit_q;
    assign respEvict    = resp_evict_q;
    assign respEvictTag = resp_evict_tag_q;
    assign valid        = valid_q;
    assign tagMat       = tag_q;

endmodule
